// File: rtl/palette_loader.sv
// Streams a 64-entry RGB palette from the ioctl download channel into the
// writable palette RAM, gating writes to vblank when that RAM is on screen.
module palette_loader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PAL_SLOT   = 14
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   input  logic [3:0]  palette,
   input  logic        vblank,
   output logic        load_color,
   output logic [23:0] load_color_data,
   output logic [5:0]  load_color_index,
   output logic        pal_loaded,
   output logic        seq_err
);

   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W      = PTR_W + 1;
   localparam int unsigned FILE_BYTES = 192;
   localparam int unsigned ENTRIES    = 64;
   localparam int unsigned ENTRY_W    = 30;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic               dl_q;
   logic [7:0]         byte_cnt;
   logic [1:0]         comp;
   logic [5:0]         ent_idx;
   logic [6:0]         wr_cnt;
   logic [7:0]         red;
   logic [7:0]         grn;
   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   logic dl_rise;
   logic dl_fall;
   logic permit;
   logic fifo_full;
   logic addr_in_file;
   logic addr_match;
   logic accept;
   logic bad_seq;
   logic push;
   logic pop;

   // Per-cycle strobes; a download restart suppresses all FIFO traffic that cycle.
   always_comb begin
      dl_rise      = ioctl_download & ~dl_q;
      dl_fall      = ~ioctl_download & dl_q;
      permit       = (palette != 4'(PAL_SLOT)) | vblank;
      fifo_full    = (count == CNT_W'(FIFO_DEPTH));
      addr_in_file = (ioctl_addr < 25'(FILE_BYTES));
      addr_match   = (ioctl_addr == 25'(byte_cnt));
      accept       = (state == LOAD) & ~dl_rise & ioctl_wr & addr_in_file & addr_match;
      bad_seq      = (state == LOAD) & ~dl_rise & ioctl_wr & addr_in_file & ~addr_match;
      pop          = (state != IDLE) & ~dl_rise & (count != '0) & permit;
      push         = accept & (comp == 2'd2) & (~fifo_full | pop);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ent_idx, red, grn, ioctl_dout};
   end

   // Edge detector resets high so a download already in progress at reset
   // release is not mistaken for a new one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         dl_q             <= 1'b1;
         byte_cnt         <= '0;
         comp             <= '0;
         ent_idx          <= '0;
         wr_cnt           <= '0;
         red              <= '0;
         grn              <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         ioctl_wait       <= 1'b0;
         load_color       <= 1'b0;
         load_color_data  <= '0;
         load_color_index <= '0;
         pal_loaded       <= 1'b0;
         seq_err          <= 1'b0;
      end else begin
         dl_q       <= ioctl_download;
         load_color <= pop;
         ioctl_wait <= (count >= CNT_W'(FIFO_DEPTH - 1));

         if (pop) begin
            load_color_index <= mem[rd_ptr][29:24];
            load_color_data  <= mem[rd_ptr][23:0];
            rd_ptr           <= rd_ptr + PTR_W'(1);
            if (wr_cnt != 7'(ENTRIES)) wr_cnt <= wr_cnt + 7'd1;
            if (wr_cnt == 7'(ENTRIES - 1)) pal_loaded <= 1'b1;
         end

         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (push & ~pop)      count <= count + CNT_W'(1);
         else if (pop & ~push) count <= count - CNT_W'(1);

         if (accept) begin
            byte_cnt <= byte_cnt + 8'd1;
            case (comp)
               2'd0: begin
                  red  <= ioctl_dout;
                  comp <= 2'd1;
               end
               2'd1: begin
                  grn  <= ioctl_dout;
                  comp <= 2'd2;
               end
               default: begin
                  comp    <= 2'd0;
                  ent_idx <= ent_idx + 6'd1;
               end
            endcase
         end

         if (bad_seq) seq_err <= 1'b1;

         case (state)
            LOAD:    if (dl_fall) state <= DRAIN;
            DRAIN:   if (count == '0) state <= IDLE;
            default: state <= state;
         endcase

         // A new download restarts from a clean slate, whatever the state.
         if (dl_rise) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            byte_cnt   <= '0;
            comp       <= '0;
            ent_idx    <= '0;
            wr_cnt     <= '0;
            pal_loaded <= 1'b0;
            seq_err    <= 1'b0;
            ioctl_wait <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader with a queue scoreboard of expected writes.
module tb_palette_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [3:0]  palette;
   logic        vblank;
   logic        load_color;
   logic [23:0] load_color_data;
   logic [5:0]  load_color_index;
   logic        pal_loaded;
   logic        seq_err;

   always #5 clk = ~clk;

   palette_loader #(.FIFO_DEPTH(4), .PAL_SLOT(14)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ioctl_download   (ioctl_download),
      .ioctl_wr         (ioctl_wr),
      .ioctl_addr       (ioctl_addr),
      .ioctl_dout       (ioctl_dout),
      .ioctl_wait       (ioctl_wait),
      .palette          (palette),
      .vblank           (vblank),
      .load_color       (load_color),
      .load_color_data  (load_color_data),
      .load_color_index (load_color_index),
      .pal_loaded       (pal_loaded),
      .seq_err          (seq_err)
   );

   int          total = 0;
   int          bad = 0;
   int          nwrites = 0;
   int          exp_cnt = 0;
   logic        model_on = 1'b0;
   logic [7:0]  mr;
   logic [7:0]  mg;
   logic [29:0] exp_q[$];
   logic [29:0] mon_e;
   logic [23:0] seen [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of the byte assembler: in-order bytes below 192 only.
   task automatic model(input int a, input logic [7:0] d);
      if (a >= 192 || a != exp_cnt) return;
      case (exp_cnt % 3)
         0:       mr = d;
         1:       mg = d;
         default: exp_q.push_back({6'(exp_cnt / 3), mr, mg, d});
      endcase
      exp_cnt++;
   endtask

   // Every load_color pulse must match the oldest outstanding expected entry.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && load_color === 1'b1) begin
         nwrites++;
         seen[load_color_index] = load_color_data;
         check("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("write_entry", {2'b00, load_color_index, load_color_data}, {2'b00, mon_e});
         end
      end
   end

   task automatic send_byte(input int a, input int d);
      int t;
      t = 0;
      while (ioctl_wait === 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("wait_timeout", 32'(t), 32'd0);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'(d);
      if (model_on) model(a, 8'(d));
      @(negedge clk);
      ioctl_wr = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_range(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) send_byte(k, k & 255);
   endtask

   task automatic start_dl();
      exp_q.delete();
      exp_cnt        = 0;
      nwrites        = 0;
      model_on       = 1'b1;
      ioctl_download = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic end_dl();
      int t;
      ioctl_download = 1'b0;
      @(negedge clk);
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("drain_complete", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      model_on = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n        = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      palette        = 4'd0;
      vblank         = 1'b0;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_load_color", 32'(load_color), 32'd0);
      check("rst_data", 32'(load_color_data), 32'd0);
      check("rst_index", 32'(load_color_index), 32'd0);
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_pal_loaded", 32'(pal_loaded), 32'd0);
      check("rst_seq_err", 32'(seq_err), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full download, palette 0: first write two cycles after the B byte.
      start_dl();
      send_range(0, 1);
      send_byte(2, 2);
      check("first_latency", 32'(load_color), 32'd1);
      send_range(3, 191);
      end_dl();
      check("full_writes", 32'(nwrites), 32'd64);
      check("full_entry1", 32'(seen[1]), 32'h030405);
      check("full_pal_loaded", 32'(pal_loaded), 32'd1);
      check("full_seq_err", 32'(seq_err), 32'd0);

      // Live writable palette outside vblank: entries queue, then drain in vblank.
      palette = 4'd14;
      vblank  = 1'b0;
      start_dl();
      send_range(0, 5);
      check("p14_wait_low", 32'(ioctl_wait), 32'd0);
      send_range(6, 8);
      repeat (2) @(negedge clk);
      check("p14_no_writes", 32'(nwrites), 32'd0);
      check("p14_wait_high", 32'(ioctl_wait), 32'd1);
      vblank = 1'b1;
      @(negedge clk);
      check("p14_drain0", 32'(load_color), 32'd1);
      @(negedge clk);
      check("p14_drain1", 32'(load_color), 32'd1);
      @(negedge clk);
      check("p14_drain2", 32'(load_color), 32'd1);
      @(negedge clk);
      check("p14_drain_end", 32'(load_color), 32'd0);
      check("p14_wait_fall", 32'(ioctl_wait), 32'd0);
      check("p14_drain_cnt", 32'(nwrites), 32'd3);
      send_range(9, 191);
      end_dl();
      check("p14_writes", 32'(nwrites), 32'd64);
      palette = 4'd0;
      vblank  = 1'b0;

      // Skipped address: flagged and dropped, the correct address still lands.
      start_dl();
      send_range(0, 5);
      send_byte(7, 7);
      @(negedge clk);
      check("skip_seq_err", 32'(seq_err), 32'd1);
      check("skip_two_writes", 32'(nwrites), 32'd2);
      send_range(6, 191);
      end_dl();
      check("skip_writes", 32'(nwrites), 32'd64);
      check("skip_seq_sticky", 32'(seq_err), 32'd1);

      // Short file: trailing partial entry discarded, then idle ignores strobes.
      start_dl();
      send_range(0, 189);
      end_dl();
      check("short_writes", 32'(nwrites), 32'd63);
      check("short_pal_loaded", 32'(pal_loaded), 32'd0);
      check("short_seq_err", 32'(seq_err), 32'd0);
      send_range(0, 5);
      repeat (3) @(negedge clk);
      check("idle_no_writes", 32'(nwrites), 32'd63);
      check("idle_seq_err", 32'(seq_err), 32'd0);

      // Reset while entry 10 sits in the FIFO.
      start_dl();
      send_range(0, 31);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'd32;
      ioctl_dout = 8'd32;
      model(32, 8'd32);
      @(negedge clk);
      ioctl_wr = 1'b0;
      reset_n  = 1'b0;
      #1;
      check("mid_rst_load_color", 32'(load_color), 32'd0);
      check("mid_rst_data", 32'(load_color_data), 32'd0);
      check("mid_rst_index", 32'(load_color_index), 32'd0);
      check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
      check("mid_rst_pal_loaded", 32'(pal_loaded), 32'd0);
      check("mid_rst_seq_err", 32'(seq_err), 32'd0);
      exp_q.delete();
      model_on = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      send_range(0, 11);
      repeat (3) @(negedge clk);
      check("post_rst_no_writes", 32'(nwrites), 32'd10);
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk);
      start_dl();
      send_range(0, 5);
      end_dl();
      check("post_rst_reload", 32'(nwrites), 32'd2);

      // Oversized file: bytes past 191 ignored without error.
      start_dl();
      send_range(0, 199);
      end_dl();
      check("long_writes", 32'(nwrites), 32'd64);
      check("long_seq_err", 32'(seq_err), 32'd0);
      check("long_pal_loaded", 32'(pal_loaded), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
